fpcvt_seq: RTL and testbench

FPCVT_SEQ -- requirements
Module: fpcvt_seq

---
 rtl/fpcvt_seq.sv | 178 +++++++++++++++++
 tb/tb_fpcvt_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fpcvt_seq.sv
// fpcvt_seq: sequential 12-bit two's-complement to sign/3-bit exponent/4-bit
// significand converter. Result value = out_f * 2^out_e, sign in out_s.
// Flow: IDLE accepts a sample, NORM shifts left one bit per cycle until
// normalised or exp reaches 0, ROUND forms the registered result, and DONE
// holds it until the consumer takes it.
// Optional feature macro: FPCVT_ROUND_EN (round-half-up on the bit below the
// significand). When it is undefined the significand is truncated.
module fpcvt_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] in_d,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_s,
    output logic [2:0]  out_e,
    output logic [3:0]  out_f,
    output logic        out_sat,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [10:0] mag_q, mag_d;
    logic [2:0]  exp_q, exp_d;
    logic        sat_q, sat_d;

    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        out_s_q, out_s_d;
    logic [2:0]  out_e_q, out_e_d;
    logic [3:0]  out_f_q, out_f_d;
    logic        out_sat_q, out_sat_d;

    logic        rnd_bit_s;
    logic [7:0]  round_res_s;

    // Magnitude of a 12-bit sample; -2048 has no 11-bit magnitude and is
    // clamped to the largest one (the caller flags saturation separately).
    function automatic logic [10:0] abs_mag(input logic [11:0] d);
        logic [11:0] neg;
        neg = ~d + 12'd1;
        if (d == 12'h800) begin
            return 11'h7FF;
        end else if (d[11]) begin
            return neg[10:0];
        end else begin
            return d[10:0];
        end
    endfunction

    // Adds the rounding bit to the significand and resolves overflow:
    // below the top exponent the result renormalises to 8 * 2^(e+1), at the
    // top exponent it clamps to 15 and flags saturation.
    // Packed result: {ovf_sat, e[2:0], f[3:0]}.
    function automatic logic [7:0] round_result(input logic [3:0] sig,
                                                input logic       rnd,
                                                input logic [2:0] e);
        logic [4:0] sum;
        sum = {1'b0, sig} + {4'd0, rnd};
        if (sum == 5'd16) begin
            if (e == 3'd7) begin
                return {1'b1, 3'd7, 4'd15};
            end else begin
                return {1'b0, e + 3'd1, 4'd8};
            end
        end else begin
            return {1'b0, e, sum[3:0]};
        end
    endfunction

`ifdef FPCVT_ROUND_EN
    assign rnd_bit_s = mag_q[6];
`else
    assign rnd_bit_s = 1'b0;
`endif

    assign round_res_s = round_result(mag_q[10:7], rnd_bit_s, exp_q);

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_s     = out_s_q;
    assign out_e     = out_e_q;
    assign out_f     = out_f_q;
    assign out_sat   = out_sat_q;

    // Next-state, datapath and output-register decode for the converter FSM.
    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        exp_d     = exp_q;
        sat_d     = sat_q;
        out_s_d   = out_s_q;
        out_e_d   = out_e_q;
        out_f_d   = out_f_q;
        out_sat_d = out_sat_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_d[11];
                    mag_d   = abs_mag(in_d);
                    exp_d   = 3'd7;
                    sat_d   = (in_d == 12'h800);
                    state_d = NORM;
                end else begin
                    state_d = IDLE;
                end
            end
            NORM: begin
                if (mag_q[10] || (exp_q == 3'd0)) begin
                    state_d = ROUND;
                end else begin
                    mag_d = {mag_q[9:0], 1'b0};
                    exp_d = exp_q - 3'd1;
                end
            end
            ROUND: begin
                out_s_d   = sign_q;
                out_e_d   = round_res_s[6:4];
                out_f_d   = round_res_s[3:0];
                out_sat_d = sat_q | round_res_s[7];
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mag_q       <= 11'd0;
            exp_q       <= 3'd0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_s_q     <= 1'b0;
            out_e_q     <= 3'd0;
            out_f_q     <= 4'd0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            exp_q       <= exp_d;
            sat_q       <= sat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_s_q     <= out_s_d;
            out_e_q     <= out_e_d;
            out_f_q     <= out_f_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_fpcvt_seq.sv
// Bench for fpcvt_seq: directed corner samples plus random samples, each
// compared against an arithmetic reference model of the number format.
module tb_fpcvt_seq;

    logic        clk;
    logic        rst;
    logic [11:0] in_d;
    logic        in_valid;
    logic        in_ready;
    logic        out_s;
    logic [2:0]  out_e;
    logic [3:0]  out_f;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;

    int total;
    int bad;

    fpcvt_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_d      (in_d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_s     (out_s),
        .out_e     (out_e),
        .out_f     (out_f),
        .out_sat   (out_sat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: value = f * 2^e with the largest 4-bit significand window
    // that fits, exponent limited to 0..7, then optional round-half-up.
    task automatic ref_model(input logic [11:0] d,
                             output int s, output int e, output int f,
                             output int sat, output int lat);
        int v, mag, p, sh, sig, fifth, rnd;
        v   = $signed(d);
        sat = 0;
        if (v == -2048) begin
            mag = 2047;
            sat = 1;
        end else begin
            mag = (v < 0) ? -v : v;
        end
        p = -1;
        for (int i = 0; i < 11; i++) begin
            if (((mag >> i) & 1) == 1) p = i;
        end
        sh = (p < 0) ? 7 : (((10 - p) > 7) ? 7 : (10 - p));
        e     = 7 - sh;
        sig   = mag >> e;
        fifth = (e > 0) ? ((mag >> (e - 1)) & 1) : 0;
`ifdef FPCVT_ROUND_EN
        rnd = fifth;
`else
        rnd = 0;
`endif
        f = sig + rnd;
        if (f == 16) begin
            if (e < 7) begin
                f = 8;
                e = e + 1;
            end else begin
                f   = 15;
                sat = 1;
            end
        end
        s   = (d[11] == 1'b1) ? 1 : 0;
        lat = sh + 2;
    endtask

    // Convert one sample; hold out_ready low for 'hold' cycles in DONE.
    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic convert(input logic [11:0] d, input int hold);
        int es, ee, ef, esat, elat, cyc;
        ref_model(d, es, ee, ef, esat, elat);
        chk("ready_before", in_ready, 1);
        in_d      = d;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("ready_busy", in_ready, 0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            in_valid = 1'($urandom_range(0, 1));
            in_d     = 12'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        if (!out_valid) begin
            chk("timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        chk("latency", cyc, elat);
        for (int h = 0; h <= hold; h++) begin
            chk("out_s", out_s, es);
            chk("out_e", out_e, ee);
            chk("out_f", out_f, ef);
            chk("out_sat", out_sat, esat);
            chk("ready_done", in_ready, 0);
            chk("valid_hold", out_valid, 1);
            if (h < hold) begin
                in_valid = 1'($urandom_range(0, 1));
                in_d     = 12'($urandom);
                @(posedge clk); #1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_clear", out_valid, 0);
        chk("ready_back", in_ready, 1);
    endtask

    initial begin
        logic [11:0] corner [8];
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_d      = 12'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        corner[0] = 12'h7FF; corner[1] = 12'h801; corner[2] = 12'h00F;
        corner[3] = 12'h010; corner[4] = 12'hFF0; corner[5] = 12'h3FF;
        corner[6] = 12'h0FF; corner[7] = 12'h001;

        #3;
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_s", out_s, 0);
        chk("rst_e", out_e, 0);
        chk("rst_f", out_f, 0);
        chk("rst_sat", out_sat, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        convert(12'h000, 0);
        convert(12'h1A6, 0);
        convert(12'h0F8, 0);
        convert(12'h800, 1);
        convert(12'hFFF, 5);

        // Reset while the sample 1 is still shifting in NORM.
        in_d     = 12'h001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_ready", in_ready, 1);
        chk("midrst_valid", out_valid, 0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_valid", out_valid, 0);
        end
        convert(12'h400, 0);

        for (int i = 0; i < 8; i++) begin
            convert(corner[i], i % 3);
        end
        for (int i = 0; i < 40; i++) begin
            convert(12'($urandom), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
